// File: rtl/rob_commit_pkg.sv
// rtl/rob_commit_pkg.sv - reorder-buffer row type and sizing shared with dispatch and RS
package rob_commit_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;

  typedef logic [IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic              v;
    logic              done;
    logic              has_dest;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic [31:0]       pc;
  } rob_row;

endpackage

// File: rtl/rob_commit_if.sv
// rtl/rob_commit_if.sv - dispatch, completion and retirement signals of the reorder buffer
interface rob_commit_if #(
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6
);
  logic              flush;
  logic              alloc_valid_1, alloc_valid_2;
  logic              alloc_has_dest_1, alloc_has_dest_2;
  logic [PREG_W-1:0] alloc_pd_1, alloc_pd_2;
  logic [PREG_W-1:0] alloc_old_pd_1, alloc_old_pd_2;
  logic [31:0]       alloc_pc_1, alloc_pc_2;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx_1, alloc_idx_2;
  logic              cmpl_valid_1, cmpl_valid_2;
  logic [IDX_W-1:0]  cmpl_idx_1, cmpl_idx_2;
  logic              commit_valid_1, commit_valid_2;
  logic [PREG_W-1:0] commit_pd_1, commit_pd_2;
  logic [PREG_W-1:0] commit_old_pd_1, commit_old_pd_2;
  logic              commit_free_1, commit_free_2;
  logic [31:0]       commit_pc_1, commit_pc_2;
  logic [IDX_W:0]    rob_count;
  logic              rob_empty, rob_full;

  modport master (
    output flush,
    output alloc_valid_1, alloc_valid_2, alloc_has_dest_1, alloc_has_dest_2,
    output alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2, alloc_pc_1, alloc_pc_2,
    input  alloc_ready, alloc_idx_1, alloc_idx_2,
    output cmpl_valid_1, cmpl_valid_2, cmpl_idx_1, cmpl_idx_2,
    input  commit_valid_1, commit_valid_2, commit_pd_1, commit_pd_2,
    input  commit_old_pd_1, commit_old_pd_2, commit_free_1, commit_free_2,
    input  commit_pc_1, commit_pc_2,
    input  rob_count, rob_empty, rob_full
  );

  modport slave (
    input  flush,
    input  alloc_valid_1, alloc_valid_2, alloc_has_dest_1, alloc_has_dest_2,
    input  alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2, alloc_pc_1, alloc_pc_2,
    output alloc_ready, alloc_idx_1, alloc_idx_2,
    input  cmpl_valid_1, cmpl_valid_2, cmpl_idx_1, cmpl_idx_2,
    output commit_valid_1, commit_valid_2, commit_pd_1, commit_pd_2,
    output commit_old_pd_1, commit_old_pd_2, commit_free_1, commit_free_2,
    output commit_pc_1, commit_pc_2,
    output rob_count, rob_empty, rob_full
  );

endinterface

// File: rtl/rob_commit_select.sv
// rtl/rob_commit_select.sv - head/head+1 retire eligibility and retire count
// Lane 2 is only active when ROB_DUAL_COMMIT_EN is defined.
module rob_commit_select
  import rob_commit_pkg::*;
(
  input  logic       head_v,
  input  logic       head_done,
  input  logic       head1_v,
  input  logic       head1_done,
  output logic       retire_1,
  output logic       retire_2,
  output logic [1:0] retire_cnt
);

  assign retire_1 = head_v && head_done;

`ifdef ROB_DUAL_COMMIT_EN
  // head+1 may only leave together with head to keep retirement in order
  assign retire_2 = retire_1 && head1_v && head1_done;
`else
  logic unused_head1;
  assign unused_head1 = head1_v ^ head1_done;
  assign retire_2     = 1'b0;
`endif

  assign retire_cnt = 2'(retire_1) + 2'(retire_2);

endmodule

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order dual-retire reorder buffer
// Define ROB_DUAL_COMMIT_EN to enable the second commit lane.
module rob_commit #(
  parameter int ROB_DEPTH = rob_commit_pkg::ROB_DEPTH,
  parameter int PREG_W    = rob_commit_pkg::PREG_W
) (
  input logic         clk,
  input logic         rst_n,
  rob_commit_if.slave rif
);
  import rob_commit_pkg::*;

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef logic [IDX_W-1:0] idx_t;

  rob_row           rob [ROB_DEPTH];
  idx_t             head, tail;
  idx_t             head_1, tail_1;
  logic [CNT_W-1:0] count;

  logic             alloc_ready;
  logic             do_alloc_1, do_alloc_2;
  logic [1:0]       alloc_cnt;
  logic             retire_1, retire_2;
  logic [1:0]       retire_cnt;
  logic             cmpl_ok_1, cmpl_ok_2;

  logic              cv1_q, cf1_q;
  logic [PREG_W-1:0] cpd1_q, cold1_q;
  logic [31:0]       cpc1_q;

  assign head_1 = head + idx_t'(1);
  assign tail_1 = tail + idx_t'(1);

  // Uses the registered count, so a retirement this cycle cannot free room early
  assign alloc_ready = (count <= CNT_W'(ROB_DEPTH - 2));
  assign do_alloc_1  = rif.alloc_valid_1 && alloc_ready;
  assign do_alloc_2  = do_alloc_1 && rif.alloc_valid_2;
  assign alloc_cnt   = 2'(do_alloc_1) + 2'(do_alloc_2);

  rob_commit_select u_select (
    .head_v     (rob[head].v),
    .head_done  (rob[head].done),
    .head1_v    (rob[head_1].v),
    .head1_done (rob[head_1].done),
    .retire_1   (retire_1),
    .retire_2   (retire_2),
    .retire_cnt (retire_cnt)
  );

  // A strobe to an entry retiring on this edge must not re-set its done bit
  assign cmpl_ok_1 = rif.cmpl_valid_1 && rob[rif.cmpl_idx_1].v
                     && !(retire_1 && rif.cmpl_idx_1 == head)
                     && !(retire_2 && rif.cmpl_idx_1 == head_1);
  assign cmpl_ok_2 = rif.cmpl_valid_2 && rob[rif.cmpl_idx_2].v
                     && !(retire_1 && rif.cmpl_idx_2 == head)
                     && !(retire_2 && rif.cmpl_idx_2 == head_1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob[i] <= '0;
      end
    end else if (rif.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob[i].v    <= 1'b0;
        rob[i].done <= 1'b0;
      end
    end else begin
      if (retire_1) begin
        rob[head].v    <= 1'b0;
        rob[head].done <= 1'b0;
      end
      if (retire_2) begin
        rob[head_1].v    <= 1'b0;
        rob[head_1].done <= 1'b0;
      end
      if (cmpl_ok_1) rob[rif.cmpl_idx_1].done <= 1'b1;
      if (cmpl_ok_2) rob[rif.cmpl_idx_2].done <= 1'b1;
      if (do_alloc_1) begin
        rob[tail] <= '{v: 1'b1, done: 1'b0, has_dest: rif.alloc_has_dest_1,
                       pd: rif.alloc_pd_1, old_pd: rif.alloc_old_pd_1, pc: rif.alloc_pc_1};
      end
      if (do_alloc_2) begin
        rob[tail_1] <= '{v: 1'b1, done: 1'b0, has_dest: rif.alloc_has_dest_2,
                         pd: rif.alloc_pd_2, old_pd: rif.alloc_old_pd_2, pc: rif.alloc_pc_2};
      end
      head  <= head + idx_t'(retire_cnt);
      tail  <= tail + idx_t'(alloc_cnt);
      count <= count + CNT_W'(alloc_cnt) - CNT_W'(retire_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv1_q   <= 1'b0;
      cf1_q   <= 1'b0;
      cpd1_q  <= '0;
      cold1_q <= '0;
      cpc1_q  <= '0;
    end else if (rif.flush) begin
      cv1_q <= 1'b0;
      cf1_q <= 1'b0;
    end else begin
      cv1_q <= retire_1;
      cf1_q <= retire_1 && rob[head].has_dest;
      if (retire_1) begin
        cpd1_q  <= rob[head].pd;
        cold1_q <= rob[head].old_pd;
        cpc1_q  <= rob[head].pc;
      end
    end
  end

`ifdef ROB_DUAL_COMMIT_EN
  logic              cv2_q, cf2_q;
  logic [PREG_W-1:0] cpd2_q, cold2_q;
  logic [31:0]       cpc2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv2_q   <= 1'b0;
      cf2_q   <= 1'b0;
      cpd2_q  <= '0;
      cold2_q <= '0;
      cpc2_q  <= '0;
    end else if (rif.flush) begin
      cv2_q <= 1'b0;
      cf2_q <= 1'b0;
    end else begin
      cv2_q <= retire_2;
      cf2_q <= retire_2 && rob[head_1].has_dest;
      if (retire_2) begin
        cpd2_q  <= rob[head_1].pd;
        cold2_q <= rob[head_1].old_pd;
        cpc2_q  <= rob[head_1].pc;
      end
    end
  end

  assign rif.commit_valid_2  = cv2_q;
  assign rif.commit_free_2   = cf2_q;
  assign rif.commit_pd_2     = cpd2_q;
  assign rif.commit_old_pd_2 = cold2_q;
  assign rif.commit_pc_2     = cpc2_q;
`else
  assign rif.commit_valid_2  = 1'b0;
  assign rif.commit_free_2   = 1'b0;
  assign rif.commit_pd_2     = '0;
  assign rif.commit_old_pd_2 = '0;
  assign rif.commit_pc_2     = '0;
`endif

  assign rif.commit_valid_1  = cv1_q;
  assign rif.commit_free_1   = cf1_q;
  assign rif.commit_pd_1     = cpd1_q;
  assign rif.commit_old_pd_1 = cold1_q;
  assign rif.commit_pc_1     = cpc1_q;

  assign rif.alloc_ready = alloc_ready;
  assign rif.alloc_idx_1 = tail;
  assign rif.alloc_idx_2 = tail_1;
  assign rif.rob_count   = count;
  assign rif.rob_empty   = (count == '0);
  assign rif.rob_full    = (count == CNT_W'(ROB_DEPTH));

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed self-checking bench for rob_commit
module tb_rob_commit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_commit_if #(.IDX_W(4), .PREG_W(6)) bus ();

  rob_commit #(.ROB_DEPTH(16), .PREG_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rif   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush            = 1'b0;
    bus.alloc_valid_1    = 1'b0;
    bus.alloc_valid_2    = 1'b0;
    bus.alloc_has_dest_1 = 1'b0;
    bus.alloc_has_dest_2 = 1'b0;
    bus.alloc_pd_1       = '0;
    bus.alloc_pd_2       = '0;
    bus.alloc_old_pd_1   = '0;
    bus.alloc_old_pd_2   = '0;
    bus.alloc_pc_1       = '0;
    bus.alloc_pc_2       = '0;
    bus.cmpl_valid_1     = 1'b0;
    bus.cmpl_valid_2     = 1'b0;
    bus.cmpl_idx_1       = '0;
    bus.cmpl_idx_2       = '0;
  endtask

  task automatic set_a1(input logic hd, input logic [5:0] pd, input logic [5:0] old, input logic [31:0] pc);
    bus.alloc_valid_1    = 1'b1;
    bus.alloc_has_dest_1 = hd;
    bus.alloc_pd_1       = pd;
    bus.alloc_old_pd_1   = old;
    bus.alloc_pc_1       = pc;
  endtask

  task automatic set_a2(input logic hd, input logic [5:0] pd, input logic [5:0] old, input logic [31:0] pc);
    bus.alloc_valid_2    = 1'b1;
    bus.alloc_has_dest_2 = hd;
    bus.alloc_pd_2       = pd;
    bus.alloc_old_pd_2   = old;
    bus.alloc_pc_2       = pc;
  endtask

  initial begin : main
    int alloc_n;
    int commit_n;
    int cyc;
    logic [3:0] mtail;
    logic [31:0] exp_pc;
    int cq[$];

    idle();
    rst_n = 1'b0;
    #12;
    check("rst_cv1", bus.commit_valid_1, 0);
    check("rst_cv2", bus.commit_valid_2, 0);
    check("rst_free1", bus.commit_free_1, 0);
    check("rst_pc1", bus.commit_pc_1, 0);
    check("rst_ready", bus.alloc_ready, 1);
    check("rst_idx1", bus.alloc_idx_1, 0);
    check("rst_idx2", bus.alloc_idx_2, 1);
    check("rst_count", bus.rob_count, 0);
    check("rst_empty", bus.rob_empty, 1);
    check("rst_full", bus.rob_full, 0);
    rst_n = 1'b1;

    // pair allocation, out-of-order completion
    set_a1(1'b1, 6'd33, 6'd5, 32'h0);
    set_a2(1'b1, 6'd34, 6'd6, 32'h4);
    tick(); idle();
    check("pair_count", bus.rob_count, 2);
    check("pair_tail", bus.alloc_idx_1, 2);
    check("pair_empty", bus.rob_empty, 0);
    bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = 4'd1;
    tick(); idle();
    check("c1_only_nocommit", bus.commit_valid_1, 0);
    bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = 4'd0;
    tick(); idle();
    check("c0_same_edge_nocommit", bus.commit_valid_1, 0);
    tick();
    check("pair_cv1", bus.commit_valid_1, 1);
    check("pair_pd1", bus.commit_pd_1, 33);
    check("pair_old1", bus.commit_old_pd_1, 5);
    check("pair_free1", bus.commit_free_1, 1);
    check("pair_pc1", bus.commit_pc_1, 32'h0);
`ifdef ROB_DUAL_COMMIT_EN
    check("pair_cv2", bus.commit_valid_2, 1);
    check("pair_old2", bus.commit_old_pd_2, 6);
    check("pair_free2", bus.commit_free_2, 1);
    check("pair_pc2", bus.commit_pc_2, 32'h4);
    check("pair_count0", bus.rob_count, 0);
    tick();
    check("pair_held_low", bus.commit_valid_1, 0);
`else
    check("pair_cv2_tied", bus.commit_valid_2, 0);
    check("pair_count1", bus.rob_count, 1);
    tick();
    check("seq_cv1", bus.commit_valid_1, 1);
    check("seq_pc1", bus.commit_pc_1, 32'h4);
    check("seq_old1", bus.commit_old_pd_1, 6);
    check("seq_count0", bus.rob_count, 0);
    tick();
    check("seq_held_low", bus.commit_valid_1, 0);
`endif

    // rd = x0 entry, both completion lanes hitting the same index
    set_a1(1'b0, 6'd0, 6'd7, 32'h100);
    tick(); idle();
    check("nodest_tail", bus.alloc_idx_1, 3);
    bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = 4'd2;
    bus.cmpl_valid_2 = 1'b1; bus.cmpl_idx_2 = 4'd2;
    tick(); idle();
    check("nodest_wait", bus.commit_valid_1, 0);
    tick();
    check("nodest_cv1", bus.commit_valid_1, 1);
    check("nodest_free1", bus.commit_free_1, 0);
    check("nodest_pc1", bus.commit_pc_1, 32'h100);

    // completion strobe to an invalid index
    set_a1(1'b1, 6'd10, 6'd11, 32'h200);
    tick(); idle();
    bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = 4'd9;
    tick(); idle();
    tick();
    check("inv9_nocommit", bus.commit_valid_1, 0);
    check("inv9_count", bus.rob_count, 1);
    bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = 4'd3;
    tick(); idle();
    tick();
    check("inv9_later_cv1", bus.commit_valid_1, 1);
    check("inv9_later_pc1", bus.commit_pc_1, 32'h200);
    check("inv9_later_empty", bus.rob_empty, 1);

    // fill to 16 with pairs, then a dropped allocation
    for (int k = 0; k < 8; k++) begin
      check("fill_ready", bus.alloc_ready, 1);
      set_a1(1'b1, 6'(2 * k), 6'd1, 32'h1000 + 32'(8 * k));
      set_a2(1'b1, 6'(2 * k + 1), 6'd2, 32'h1004 + 32'(8 * k));
      tick(); idle();
    end
    check("full_count", bus.rob_count, 16);
    check("full_flag", bus.rob_full, 1);
    check("full_ready", bus.alloc_ready, 0);
    check("full_tail", bus.alloc_idx_1, 4);
    set_a1(1'b1, 6'd9, 6'd9, 32'hdead);
    tick(); idle();
    check("drop16_count", bus.rob_count, 16);
    check("drop16_tail", bus.alloc_idx_1, 4);
    check("drop16_nocommit", bus.commit_valid_1, 0);
    bus.flush = 1'b1;
    tick(); idle();
    check("flush1_count", bus.rob_count, 0);
    check("flush1_empty", bus.rob_empty, 1);
    check("flush1_tail", bus.alloc_idx_1, 0);

    // fill to 15: not ready, not full
    for (int k = 0; k < 7; k++) begin
      set_a1(1'b1, 6'd1, 6'd1, 32'h3000 + 32'(8 * k));
      set_a2(1'b1, 6'd2, 6'd2, 32'h3004 + 32'(8 * k));
      tick(); idle();
    end
    set_a1(1'b1, 6'd3, 6'd3, 32'h3038);
    tick(); idle();
    check("c15_count", bus.rob_count, 15);
    check("c15_ready", bus.alloc_ready, 0);
    check("c15_full", bus.rob_full, 0);
    set_a1(1'b1, 6'd4, 6'd4, 32'h4000);
    set_a2(1'b1, 6'd4, 6'd4, 32'h4004);
    tick(); idle();
    check("drop15_count", bus.rob_count, 15);
    check("drop15_tail", bus.alloc_idx_1, 15);

    // flush beats a pending commit, allocation and completion
    bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = 4'd0;
    tick(); idle();
    check("pre_flush_nocommit", bus.commit_valid_1, 0);
    bus.flush = 1'b1;
    set_a1(1'b1, 6'd5, 6'd5, 32'h5000);
    bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = 4'd1;
    tick(); idle();
    check("flush2_cv1", bus.commit_valid_1, 0);
    check("flush2_count", bus.rob_count, 0);
    check("flush2_empty", bus.rob_empty, 1);
    check("flush2_tail", bus.alloc_idx_1, 0);
    tick();
    check("flush2_after_cv1", bus.commit_valid_1, 0);

    // asynchronous reset while a commit is pending
    set_a1(1'b1, 6'd6, 6'd6, 32'h300);
    set_a2(1'b1, 6'd7, 6'd7, 32'h304);
    tick(); idle();
    bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = 4'd0;
    bus.cmpl_valid_2 = 1'b1; bus.cmpl_idx_2 = 4'd1;
    tick(); idle();
    #1 rst_n = 1'b0;
    #1;
    check("arst_count", bus.rob_count, 0);
    check("arst_empty", bus.rob_empty, 1);
    #1 rst_n = 1'b1;
    tick();
    check("arst_nocommit", bus.commit_valid_1, 0);
    check("arst_count_after", bus.rob_count, 0);

    // continuous stream of 40 instructions across the 15->0 wrap
    alloc_n  = 0;
    commit_n = 0;
    cyc      = 0;
    mtail    = 4'd0;
    exp_pc   = 32'h2000;
    while (commit_n < 40 && cyc < 500) begin
      idle();
      if (cq.size() > 0) begin
        bus.cmpl_valid_1 = 1'b1;
        bus.cmpl_idx_1   = 4'(cq.pop_front());
      end
      if (cq.size() > 0) begin
        bus.cmpl_valid_2 = 1'b1;
        bus.cmpl_idx_2   = 4'(cq.pop_front());
      end
      if (alloc_n < 40 && bus.alloc_ready) begin
        check("stream_idx", bus.alloc_idx_1, 32'(mtail));
        set_a1(1'b1, 6'(alloc_n), 6'(alloc_n + 1), 32'h2000 + 32'(4 * alloc_n));
        cq.push_back(int'(mtail));
        mtail = mtail + 4'd1;
        alloc_n++;
        if (alloc_n < 40) begin
          set_a2(1'b1, 6'(alloc_n), 6'(alloc_n + 1), 32'h2000 + 32'(4 * alloc_n));
          cq.push_back(int'(mtail));
          mtail = mtail + 4'd1;
          alloc_n++;
        end
      end
      tick();
      if (bus.commit_valid_1) begin
        check("stream_pc1", bus.commit_pc_1, exp_pc);
        exp_pc = exp_pc + 32'd4;
        commit_n++;
      end
      if (bus.commit_valid_2) begin
        check("stream_pc2", bus.commit_pc_2, exp_pc);
        exp_pc = exp_pc + 32'd4;
        commit_n++;
      end
      check("stream_count_le16", 32'(bus.rob_count <= 5'd16), 1);
      cyc++;
    end
    idle();
    check("stream_commits", commit_n, 40);
    check("stream_empty", bus.rob_empty, 1);
    check("stream_tail_wrap", bus.alloc_idx_1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
